// File: rtl/fg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : fg_pkg                                                           |
// | Brief   : Shared types and sizing helpers for the FG CORDIC scheduler.     |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package fg_pkg;

    // Widest channel index supported (NUM_CH up to 16).
    localparam int c_ch_w_max = 4;

    typedef struct packed {
        logic                  valid;
        logic [c_ch_w_max-1:0] ch;
    } tag_t;

    function automatic int ch_width(input int num_ch);
        return (num_ch <= 2) ? 1 : $clog2(num_ch);
    endfunction

    // Input register plus (bitwidth-1) rotation iterations.
    function automatic int cordic_latency(input int bitwidth);
        return bitwidth;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fg_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : fg_rr_arbiter                                                     |
// | Brief  : Combinational round-robin arbiter, first requester at or above    |
// |          the pointer wins, wrapping to the lowest requester otherwise.     |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module fg_rr_arbiter
    import fg_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int c_ch_w = ch_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [c_ch_w-1:0] i_pointer,
    input  logic              i_advance,
    output logic [NUM_CH-1:0] o_grant,
    output logic [c_ch_w-1:0] o_winner,
    output logic [c_ch_w-1:0] o_next_pointer
);

    logic              w_hit_hi;
    logic              w_hit_any;
    logic [c_ch_w-1:0] w_win_hi;
    logic [c_ch_w-1:0] w_win_any;

    // Descending scan so the lowest qualifying index is the last one written.
    always_comb begin
        w_hit_hi  = 1'b0;
        w_win_hi  = '0;
        w_hit_any = 1'b0;
        w_win_any = '0;
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (i_req[j]) begin
                w_hit_any = 1'b1;
                w_win_any = c_ch_w'(j);
                if (c_ch_w'(j) >= i_pointer) begin
                    w_hit_hi = 1'b1;
                    w_win_hi = c_ch_w'(j);
                end
            end
        end
    end

    assign o_winner = w_hit_hi ? w_win_hi : w_win_any;

    always_comb begin
        o_grant = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            o_grant[j] = i_advance && w_hit_any && (o_winner == c_ch_w'(j));
        end
    end

    assign o_next_pointer = (o_winner == c_ch_w'(NUM_CH - 1)) ? '0 : o_winner + c_ch_w'(1);

endmodule
`default_nettype wire

// File: rtl/fg_cordic_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : fg_cordic_scheduler                                               |
// | Brief  : Time-shares one pipelined CORDIC between NUM_CH function          |
// |          generator channels; results return tagged with their channel.    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module fg_cordic_scheduler
    import fg_pkg::*;
#(
    parameter  int BITWIDTH       = 8,
    parameter  int BITWIDTH_PHASE = 10,
    parameter  int NUM_CH         = 4,
    parameter  int LATENCY        = cordic_latency(BITWIDTH),
    localparam int c_ch_w         = ch_width(NUM_CH)
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic                         clk_en_i,
    input  logic                         enable_i,
    input  logic [NUM_CH-1:0]            req_i,
    input  logic [NUM_CH*BITWIDTH_PHASE-1:0] phase_i,
    input  logic [NUM_CH*BITWIDTH-1:0]   amp_i,
    output logic [NUM_CH-1:0]            ack_o,
    output logic                         cordic_clk_en_o,
    output logic [BITWIDTH_PHASE-1:0]    cordic_phase_o,
    output logic [BITWIDTH-1:0]          cordic_x_o,
    output logic [BITWIDTH-1:0]          cordic_y_o,
    input  logic [BITWIDTH:0]            cordic_cos_i,
    input  logic [BITWIDTH:0]            cordic_sin_i,
    output logic                         res_valid_o,
    output logic [c_ch_w-1:0]            res_ch_o,
    output logic [BITWIDTH:0]            res_cos_o,
    output logic [BITWIDTH:0]            res_sin_o,
    output logic                         idle_o
);

    logic [c_ch_w-1:0] r_ptr;
    logic [c_ch_w-1:0] w_winner;
    logic [c_ch_w-1:0] w_next_ptr;
    logic [NUM_CH-1:0] w_ack;
    logic              w_advance;
    logic              w_grant;
    logic              w_busy;
    logic              w_unused_ch;
    tag_t              r_tag [LATENCY];

    logic              r_res_valid;
    logic [c_ch_w-1:0] r_res_ch;
    logic [BITWIDTH:0] r_res_cos;
    logic [BITWIDTH:0] r_res_sin;

    assign w_advance = clk_en_i & enable_i;

    fg_rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .i_req          (req_i),
        .i_pointer      (r_ptr),
        .i_advance      (w_advance),
        .o_grant        (w_ack),
        .o_winner       (w_winner),
        .o_next_pointer (w_next_ptr)
    );

    assign w_grant         = |w_ack;
    assign ack_o           = w_ack;
    assign cordic_clk_en_o = clk_en_i;
    assign cordic_y_o      = '0;

    // One-hot mux: the CORDIC registers the granted slice on the grant edge.
    always_comb begin
        cordic_phase_o = '0;
        cordic_x_o     = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (w_ack[j]) begin
                cordic_phase_o = phase_i[j*BITWIDTH_PHASE +: BITWIDTH_PHASE];
                cordic_x_o     = amp_i[j*BITWIDTH +: BITWIDTH];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_ptr <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                r_tag[k] <= '0;
            end
        end else if (clk_en_i) begin
            if (w_grant) begin
                r_ptr <= w_next_ptr;
            end
            r_tag[0] <= tag_t'{valid: w_grant, ch: c_ch_w_max'(w_winner)};
            for (int k = 1; k < LATENCY; k++) begin
                r_tag[k] <= r_tag[k-1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_res_valid <= 1'b0;
            r_res_ch    <= '0;
            r_res_cos   <= '0;
            r_res_sin   <= '0;
        end else if (clk_en_i && r_tag[LATENCY-1].valid) begin
            r_res_valid <= 1'b1;
            r_res_ch    <= r_tag[LATENCY-1].ch[c_ch_w-1:0];
            r_res_cos   <= cordic_cos_i;
            r_res_sin   <= cordic_sin_i;
        end else begin
            r_res_valid <= 1'b0;
        end
    end

    // Tag index is stored at the package-wide width; only c_ch_w bits matter.
    assign w_unused_ch = ^r_tag[LATENCY-1].ch;

    always_comb begin
        w_busy = w_grant;
        for (int k = 0; k < LATENCY; k++) begin
            w_busy |= r_tag[k].valid;
        end
    end

    assign idle_o      = ~w_busy;
    assign res_valid_o = r_res_valid;
    assign res_ch_o    = r_res_ch;
    assign res_cos_o   = r_res_cos;
    assign res_sin_o   = r_res_sin;

endmodule
`default_nettype wire

// File: doc/fg_cordic_scheduler.md
Name: fg_cordic_scheduler

Overview:
Time-shares one pipelined FG_Cordic instance between NUM_CH function-generator channels.
- Round-robin arbitration accepts at most one channel request per enabled clock.
- Drives the CORDIC inputs and tracks each in-flight sample with a tag pipeline matched to the CORDIC latency.
- Returns each result on a single registered result stream labelled with its channel ID.
- Sits between the per-channel phase accumulators and the CORDIC/output DAC formatting.

Parameters:
- BITWIDTH, 8: CORDIC amplitude width; result width is BITWIDTH+1.
- BITWIDTH_PHASE, 10: phase width, signed, full circle maps to 2^BITWIDTH_PHASE.
- NUM_CH, 4: number of requesting channels, range 1..16.
- LATENCY, BITWIDTH: CORDIC pipeline depth in enabled clocks (input register plus BITWIDTH-1 iterations).

Ports:
- clk_i, in, 1: clock.
- rstn_i, in, 1: asynchronous active-low reset.
- clk_en_i, in, 1: global clock enable; all state advances only when high.
- enable_i, in, 1: when low, no new grants; in-flight samples drain normally.
- req_i, in, NUM_CH: per-channel request; hold high with data stable until ack.
- phase_i, in, NUM_CH*BITWIDTH_PHASE: packed per-channel phases, channel 0 in LSBs.
- amp_i, in, NUM_CH*BITWIDTH: packed per-channel signed amplitudes.
- ack_o, out, NUM_CH: one-hot combinational grant; transfer occurs at the rising edge while high.
- cordic_clk_en_o, out, 1: equals clk_en_i.
- cordic_phase_o, out, BITWIDTH_PHASE: granted phase; 0 when there is no grant.
- cordic_x_o, out, BITWIDTH: granted amplitude; 0 when there is no grant.
- cordic_y_o, out, BITWIDTH: constant 0.
- cordic_cos_i, in, BITWIDTH+1: CORDIC cosine output.
- cordic_sin_i, in, BITWIDTH+1: CORDIC sine output.
- res_valid_o, out, 1: one-clk_i-cycle pulse per completed sample.
- res_ch_o, out, clog2(NUM_CH) (min 1): channel ID of the result.
- res_cos_o, out, BITWIDTH+1: registered cosine result.
- res_sin_o, out, BITWIDTH+1: registered sine result.
- idle_o, out, 1: high when no tag is valid and no grant is active.

Behaviour:
- Reset values:
  - tags all invalid; RR pointer = 0.
  - res_valid_o = 0, res_ch_o = 0, res_cos_o = 0, res_sin_o = 0.
  - idle_o = 1; ack_o = 0.
- Grant condition: grant = clk_en_i & enable_i & |req_i.
  - Winner is the first requesting channel at or after the pointer, searching upward with wrap.
  - ack_o is one-hot and combinational, at most one bit set per cycle.
- Pointer update: on a granted edge, pointer <= winner+1, wrapping NUM_CH-1 -> 0. No grant: pointer holds.
- CORDIC inputs are combinational muxes of the winner's slice, so the CORDIC registers the sample at the grant edge.
- Tag pipeline: LATENCY entries of {valid, ch}.
  - On each edge with clk_en_i=1: tag[0] <= {grant, winner}; tag[k] <= tag[k-1].
  - With clk_en_i=0 the tags hold.
- Capture: on an edge with clk_en_i=1 and tag[LATENCY-1].valid:
  - res_cos_o/res_sin_o <= cordic_cos_i/cordic_sin_i; res_ch_o <= tag ch; res_valid_o <= 1.
  - On every other edge res_valid_o <= 0. Data outputs hold between captures.
- Latency with clk_en_i held high: grant at edge t0 -> res_valid_o high in the cycle after edge t0+LATENCY (8 cycles by default). With gated clk_en_i, latency is LATENCY enabled edges.
- Throughput: one sample per enabled cycle; back-to-back results produce consecutive res_valid_o pulses.
- A request dropped before ack is ignored; there is no queuing.
- A request held after ack is re-arbitrated as a new sample.
- enable_i falling with samples in flight: those samples still complete. idle_o rises after the last capture edge.
- Reset mid-operation: all tags are cleared, so no stale res_valid_o appears after release even though CORDIC data is stale.
- Phase is passed unmodified; quadrant folding is the CORDIC's job.
- NUM_CH=1: the pointer stays at 0 and res_ch_o is 0.

Decomposition:
- Package fg_pkg:
  - CH_W = max(1, clog2(NUM_CH)).
  - tag struct {valid, ch[CH_W]}.
  - LATENCY default derived from BITWIDTH.
- Sub-module fg_rr_arbiter (NUM_CH): inputs req, pointer, advance. Outputs one-hot grant, winner index, next pointer.

Test Plan:
- Single request, ch0, amp=100, phase=0, clk_en_i=1, real FG_Cordic: ack_o=0001 for 1 cycle; res_valid_o after 8 cycles, res_ch_o=0, cos≈164±2, sin≈0±2.
- All 4 req held for 8 enabled cycles, pointer=0: grant order 0,1,2,3,0,1,2,3; results appear in the same order on 8 consecutive cycles.
- ch2 phase=+256 (90°), amp=100: res_ch_o=2, cos≈0±2, sin≈164±2. ch3 phase=-256: sin≈-164±2.
- clk_en_i toggled 1,0,1,0,... with one grant: result after 8 enabled edges (about 16 cycles); res_valid_o is a single 1-cycle pulse; no grant occurs while clk_en_i=0.
- Grants at 3 consecutive cycles, then rstn_i pulsed low 2 cycles later: outputs return to 0 immediately, no res_valid_o afterwards, idle_o=1.
- enable_i=0 with req_i=1111 for 10 cycles: ack_o=0000, idle_o=1; enable_i then raised: grant goes to the saved pointer channel.
